// File: rtl/cm_pkg.sv
// cm_pkg: shared direction indices, port FSM states and bit helpers for the IM-side allocator.
package cm_pkg;
  localparam int DIR_S = 0;
  localparam int DIR_W = 1;
  localparam int DIR_N = 2;
  localparam int DIR_E = 3;
  localparam int DIR_L = 4;
  typedef enum logic [2:0] {IDLE, SEEK, WAIT, HOLD, RLS} pst_e;
  function automatic logic [31:0] lsb(input logic [31:0] v);
    return v & (~v + 32'd1);
  endfunction
  function automatic int oh2idx(input logic [31:0] v);
    int r = 0;
    for (int i = 0; i < 32; i++) if (v[i]) r = r | i;
    return r;
  endfunction
endpackage

// File: rtl/im_cm_alloc_if.sv
// im_cm_alloc_if: IM input ports on one side, IM-to-CM request/grant links on the other.
interface im_cm_alloc_if #(parameter int IPN = 4, parameter int CMN = 5, parameter int DIRN = 5);
  logic [IPN-1:0] req_vld;
  logic [IPN-1:0][DIRN-1:0] req_dir;
  logic [IPN-1:0] req_rel;
  logic [IPN-1:0] req_gnt;
  logic [IPN-1:0][CMN-1:0] req_cm;
  logic [CMN-1:0][DIRN-1:0] cm_req;
  logic [CMN-1:0][DIRN-1:0] cm_ack;
  logic [CMN-1:0] cms;
  modport master (output req_vld, req_dir, req_rel, cm_ack, cms, input req_gnt, req_cm, cm_req);
  modport slave (input req_vld, req_dir, req_rel, cm_ack, cms, output req_gnt, req_cm, cm_req);
endinterface

// File: rtl/rr_arb.sv
// rr_arb: round-robin arbiter, grants the first request at or after ptr (wrapping).
module rr_arb #(parameter int N = 4, parameter int W = (N > 1) ? $clog2(N) : 1) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt
);
  always_comb begin
    int sh;
    sh = 0;
    gnt = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sh = (int'(ptr) + k) % N;
      if (|(req & (N'(1) << sh))) gnt = N'(1) << sh;
    end
  end
endmodule

// File: rtl/im_cm_alloc.sv
// im_cm_alloc: per-input-port FSMs claim a free CM, hold its direction request through the
// four-phase grant/release handshake, and time out stalled requests with a one-shot retry.
module im_cm_alloc import cm_pkg::*; #(
  parameter int IPN = 4,
  parameter int CMN = 5,
  parameter int DIRN = 5,
  parameter int TOW = 4
) (
  input logic clk,
  input logic rst_n,
  im_cm_alloc_if.slave bus
);
  localparam int PW = (IPN > 1) ? $clog2(IPN) : 1;
  localparam int CW = (CMN > 1) ? $clog2(CMN) : 1;
  localparam int DW = (DIRN > 1) ? $clog2(DIRN) : 1;
  localparam logic [TOW-1:0] TLIM = TOW'((1 << TOW) - 2);
  pst_e st [IPN];
  pst_e nst [IPN];
  logic [CW-1:0] sel [IPN];
  logic [CW-1:0] nsel [IPN];
  logic [DW-1:0] dir [IPN];
  logic [TOW-1:0] tmr [IPN];
  logic [IPN-1:0] retry, seek, pgnt, gnt_n;
  logic [PW-1:0] pptr, pwin;
  logic [CW-1:0] cptr, ccm, rty_cm;
  logic [CMN-1:0] owned, cgnt;
  logic [IPN-1:0][CMN-1:0] rcm_n;
  logic [CMN-1:0][DIRN-1:0] creq_n;
  logic claim, rty;
  always_comb begin
    owned = '0;
    seek = '0;
    for (int i = 0; i < IPN; i++) begin
      seek[i] = st[i] == SEEK && bus.req_vld[i];
      if (st[i] inside {WAIT, HOLD, RLS}) owned[sel[i]] = 1'b1;
    end
  end
  rr_arb #(.N(IPN), .W(PW)) u_parb (.req(seek), .ptr(pptr), .gnt(pgnt));
  rr_arb #(.N(CMN), .W(CW)) u_carb (.req(bus.cms & ~owned), .ptr(cptr), .gnt(cgnt));
  assign claim = |pgnt && |cgnt;
  assign pwin = PW'(oh2idx(32'(pgnt)));
  assign ccm = CW'(oh2idx(32'(cgnt)));
  always_comb begin
    logic ack;
    ack = 1'b0;
    rty = 1'b0;
    rty_cm = '0;
    gnt_n = '0;
    rcm_n = '0;
    creq_n = '0;
    for (int i = 0; i < IPN; i++) begin
      ack = bus.cm_ack[sel[i]][dir[i]];
      nst[i] = st[i];
      case (st[i])
        IDLE: nst[i] = bus.req_vld[i] && |bus.req_dir[i] ? SEEK : IDLE;
        SEEK: nst[i] = !bus.req_vld[i] ? IDLE : (claim && pgnt[i]) ? WAIT : SEEK;
        WAIT: nst[i] = !bus.req_vld[i] ? RLS : ack ? HOLD : (tmr[i] == TLIM) ? RLS : WAIT;
        HOLD: nst[i] = bus.req_rel[i] ? RLS : HOLD;
        RLS:  nst[i] = ack ? RLS : (retry[i] && bus.req_vld[i]) ? SEEK : IDLE;
        default: nst[i] = IDLE;
      endcase
      if (st[i] == RLS && nst[i] == SEEK) begin
        rty = 1'b1;
        rty_cm = sel[i];
      end
      nsel[i] = (claim && pgnt[i]) ? ccm : sel[i];
      gnt_n[i] = nst[i] == HOLD;
      rcm_n[i] = (nst[i] inside {WAIT, HOLD, RLS}) ? CMN'(1) << nsel[i] : '0;
      if (nst[i] inside {WAIT, HOLD}) creq_n[nsel[i]][dir[i]] = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < IPN; i++) begin
        st[i] <= IDLE;
        sel[i] <= '0;
        dir[i] <= '0;
        tmr[i] <= '0;
      end
      retry <= '0;
      pptr <= '0;
      cptr <= '0;
      bus.req_gnt <= '0;
      bus.req_cm <= '0;
      bus.cm_req <= '0;
    end else begin
      if (claim) begin
        pptr <= (pwin == PW'(IPN - 1)) ? '0 : pwin + 1'b1;
        cptr <= (ccm == CW'(CMN - 1)) ? '0 : ccm + 1'b1;
      end else if (rty) cptr <= (rty_cm == CW'(CMN - 1)) ? '0 : rty_cm + 1'b1;
      for (int i = 0; i < IPN; i++) begin
        st[i] <= nst[i];
        sel[i] <= nsel[i];
        if (st[i] == IDLE) dir[i] <= DW'(oh2idx(lsb(32'(bus.req_dir[i]))));
        tmr[i] <= (st[i] == WAIT) ? tmr[i] + 1'b1 : '0;
        if (st[i] == WAIT && nst[i] == RLS) retry[i] <= bus.req_vld[i];
        else if (nst[i] != RLS) retry[i] <= 1'b0;
      end
      bus.req_gnt <= gnt_n;
      bus.req_cm <= rcm_n;
      bus.cm_req <= creq_n;
    end
endmodule

// File: tb/tb_im_cm_alloc.sv
// tb_im_cm_alloc: directed vectors against hand-computed allocator outputs.
module tb_im_cm_alloc;
  import cm_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  im_cm_alloc_if bus ();
  im_cm_alloc dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic idle_in();
    bus.req_vld = '0;
    bus.req_dir = '0;
    bus.req_rel = '0;
    bus.cm_ack = '0;
    bus.cms = '1;
  endtask
  task automatic do_reset();
    idle_in();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask
  task automatic all_req();
    bus.req_vld = '1;
    for (int i = 0; i < 4; i++) bus.req_dir[i] = 5'(1 << i);
  endtask
  initial begin
    int n;
    idle_in();
    tick(2);
    chk("rst_gnt", 32'(bus.req_gnt), 32'h0);
    chk("rst_rcm", 32'(bus.req_cm), 32'h0);
    chk("rst_creq", 32'(bus.cm_req), 32'h0);
    rst_n = 1'b1;
    tick();
    // single request, direction N
    bus.req_vld[0] = 1'b1;
    bus.req_dir[0] = 5'(1 << DIR_N);
    tick(2);
    chk("t1_creq", 32'(bus.cm_req), 32'h4);
    chk("t1_rcm", 32'(bus.req_cm), 32'h1);
    chk("t1_gnt0", 32'(bus.req_gnt), 32'h0);
    bus.cm_ack[0][DIR_N] = 1'b1;
    tick();
    chk("t1_gnt", 32'(bus.req_gnt), 32'h1);
    chk("t1_hold_creq", 32'(bus.cm_req), 32'h4);
    tick(3);
    chk("t1_hold", 32'(bus.req_gnt), 32'h1);
    bus.req_rel[0] = 1'b1;
    tick();
    chk("t1_rls_creq", 32'(bus.cm_req), 32'h0);
    chk("t1_rls_gnt", 32'(bus.req_gnt), 32'h0);
    chk("t1_rls_rcm", 32'(bus.req_cm), 32'h1);
    bus.req_rel[0] = 1'b0;
    tick(2);
    chk("t1_rls_hold", 32'(bus.req_cm), 32'h1);
    bus.cm_ack = '0;
    bus.req_vld = '0;
    tick();
    chk("t1_idle", 32'(bus.req_cm), 32'h0);
    do_reset();
    // contention: ports claim CM0..CM3 on successive cycles
    all_req();
    tick(2);
    chk("t2_c0", 32'(bus.req_cm), 32'h00001);
    tick();
    chk("t2_c1", 32'(bus.req_cm), 32'h00041);
    tick();
    chk("t2_c2", 32'(bus.req_cm), 32'h01041);
    tick();
    chk("t2_c3", 32'(bus.req_cm), 32'h41041);
    chk("t2_creq", 32'(bus.cm_req), 32'h41041);
    do_reset();
    // busy CMs: only CM1 and CM4 accept
    bus.cms = 5'b10010;
    all_req();
    tick(3);
    chk("t3_rcm", 32'(bus.req_cm), 32'h202);
    chk("t3_creq", 32'(bus.cm_req), 32'h200020);
    tick(3);
    chk("t3_stall_rcm", 32'(bus.req_cm), 32'h202);
    chk("t3_stall_creq", 32'(bus.cm_req), 32'h200020);
    bus.cms = '1;
    tick();
    chk("t3_free_rcm", 32'(bus.req_cm), 32'h602);
    chk("t3_free_creq", 32'(bus.cm_req), 32'h200024);
    do_reset();
    // timeout then retry on next CM, then ack on the last WAIT cycle
    bus.req_vld[0] = 1'b1;
    bus.req_dir[0] = 5'(1 << DIR_N);
    n = 0;
    while (bus.cm_req == '0 && n < 10) begin tick(); n++; end
    chk("t4_start", 32'(bus.cm_req), 32'h4);
    n = 0;
    while (bus.cm_req != '0 && n < 40) begin tick(); n++; end
    chk("t4_len", 32'(n), 32'd15);
    n = 0;
    while (bus.cm_req == '0 && n < 10) begin tick(); n++; end
    chk("t4_gap", 32'(n), 32'd2);
    chk("t4_skip", 32'(bus.req_cm), 32'h2);
    chk("t4_retry_creq", 32'(bus.cm_req), 32'h80);
    tick(14);
    bus.cm_ack[1][DIR_N] = 1'b1;
    tick();
    chk("t4_ack_gnt", 32'(bus.req_gnt), 32'h1);
    chk("t4_ack_creq", 32'(bus.cm_req), 32'h80);
    do_reset();
    // abort in WAIT while ack is high
    bus.req_vld[0] = 1'b1;
    bus.req_dir[0] = 5'(1 << DIR_E);
    tick(2);
    chk("t5_creq", 32'(bus.cm_req), 32'h8);
    bus.cm_ack[0][DIR_E] = 1'b1;
    bus.req_vld[0] = 1'b0;
    tick();
    chk("t5_abort_creq", 32'(bus.cm_req), 32'h0);
    chk("t5_abort_gnt", 32'(bus.req_gnt), 32'h0);
    chk("t5_abort_rcm", 32'(bus.req_cm), 32'h1);
    tick(2);
    chk("t5_rls_hold", 32'(bus.req_cm), 32'h1);
    bus.cm_ack = '0;
    tick();
    chk("t5_idle", 32'(bus.req_cm), 32'h0);
    do_reset();
    // async reset during HOLD, then fresh request from pointer 0
    bus.req_vld[0] = 1'b1;
    bus.req_dir[0] = 5'(1 << DIR_L);
    tick(2);
    chk("t6_creq", 32'(bus.cm_req), 32'h10);
    bus.cm_ack[0][DIR_L] = 1'b1;
    tick();
    chk("t6_gnt", 32'(bus.req_gnt), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_gnt", 32'(bus.req_gnt), 32'h0);
    chk("t6_rst_creq", 32'(bus.cm_req), 32'h0);
    chk("t6_rst_rcm", 32'(bus.req_cm), 32'h0);
    idle_in();
    tick();
    rst_n = 1'b1;
    bus.req_vld[2] = 1'b1;
    bus.req_dir[2] = 5'(1 << DIR_S);
    tick(2);
    chk("t6_fresh_rcm", 32'(bus.req_cm), 32'h400);
    chk("t6_fresh_creq", 32'(bus.cm_req), 32'h1);
    do_reset();
    // multi-hot direction uses lowest bit; zero direction never leaves IDLE
    bus.req_vld[1] = 1'b1;
    bus.req_dir[1] = 5'b10110;
    bus.req_vld[3] = 1'b1;
    bus.req_dir[3] = 5'b00000;
    tick(2);
    chk("t7_rcm", 32'(bus.req_cm), 32'h20);
    chk("t7_creq", 32'(bus.cm_req), 32'h2);
    tick(3);
    chk("t7_zero_dir", 32'(bus.req_cm), 32'h20);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
